// File: rtl/uart_tx_seq_if.sv
// Handshake, pin and baud-timer signals of the UART transmit frame sequencer.
// The sequencer takes the slave side; the CPU/timer/pin environment takes the master side.
interface uart_tx_seq_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       txd;
    logic       tmr_load;
    logic [7:0] tmr_value;
    logic       tmr_co;

    modport master (
        output tx_data, tx_valid, tmr_co,
        input  tx_ready, tx_busy, tx_done, txd, tmr_load, tmr_value
    );

    modport slave (
        input  tx_data, tx_valid, tmr_co,
        output tx_ready, tx_busy, tx_done, txd, tmr_load, tmr_value
    );
endinterface

// File: rtl/uart_tx_seq.sv
// UART transmit frame sequencer: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Bit timing comes from an external loadable baud down-counter via tmr_load / tmr_co.
module uart_tx_seq #(
    parameter int BAUD_DIV  = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          CLOCK,
    input  logic          reset,
    uart_tx_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q,   cnt_d;
    logic       par_q,   par_d;
    logic       stop_q,  stop_d;
    logic       txd_q,   txd_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic last_stop;
    logic ready;
    logic accept;
    logic load;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        stop_d  = stop_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;

        last_stop = (STOP_BITS == 1) || stop_q;
        // Ready is held low during reset so a pending tx_valid cannot strobe the timer.
        ready  = !reset && ((state_q == S_IDLE) ||
                            (state_q == S_STOP && bus.tmr_co && last_stop));
        accept = ready && bus.tx_valid;

        case (state_q)
            S_IDLE: ;
            S_START: begin
                if (bus.tmr_co) begin
                    txd_d   = shift_q[0];
                    state_d = S_DATA;
                    load    = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.tmr_co) begin
                    load = 1'b1;
                    if (cnt_q != 3'd7) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                        cnt_d   = cnt_q + 3'd1;
                    end else if (PARITY != 0) begin
                        state_d = S_PAR;
                        txd_d   = (PARITY == 2) ? ~par_q : par_q;
                    end else begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (bus.tmr_co) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    stop_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            S_STOP: begin
                if (bus.tmr_co) begin
                    if (!last_stop) begin
                        stop_d = 1'b1;
                        load   = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept overrides the final-stop return to IDLE, giving a gapless back-to-back start.
        if (accept) begin
            load    = 1'b1;
            shift_d = bus.tx_data;
            par_d   = ^bus.tx_data;
            cnt_d   = 3'd0;
            stop_d  = 1'b0;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_START;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= 8'd0;
            cnt_q   <= 3'd0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_ready  = ready;
    assign bus.tmr_load  = load;
    assign bus.tmr_value = 8'(BAUD_DIV - 1);
    assign bus.txd       = txd_q;
    assign bus.tx_busy   = busy_q;
    assign bus.tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_seq.sv
// Self-checking bench for uart_tx_seq: several configurations, each with a behavioural baud timer,
// checked cycle by cycle against a frame-level model built from bit lists.
module tb_uart_tx_seq;

    localparam int NI = 5;

    function automatic int baud_of(input int g);
        return (g == 4) ? 2 : 4;
    endfunction

    function automatic int par_of(input int g);
        return (g == 1) ? 1 : (g == 2) ? 2 : 0;
    endfunction

    function automatic int stop_of(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int g);
        return (9 + ((par_of(g) != 0) ? 1 : 0) + stop_of(g)) * baud_of(g);
    endfunction

    // Expected line level for bit slot idx of a frame carrying byte b.
    function automatic logic exp_bit(input int g, input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (par_of(g) != 0 && idx == 9) begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(b[i]);
            return (par_of(g) == 1) ? logic'(ones % 2) : logic'((ones + 1) % 2);
        end
        return 1'b1;
    endfunction

    logic clk;
    logic reset;
    logic [NI-1:0][7:0] data_v;
    logic [NI-1:0]      valid_v;
    logic [NI-1:0]      spur_v;
    logic [NI-1:0]      txd_v, busy_v, done_v, ready_v, load_v;
    logic [NI-1:0][7:0] value_v;

    int n_checks = 0;
    int n_fail   = 0;

    logic obs_bits[$];
    int   busy_cnt;
    int   load_cnt;
    int   done_at;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        uart_tx_seq_if bus ();
        logic [7:0] cnt;
        logic       run;

        // Behavioural shared baud timer: load V, count down, one terminal pulse at zero.
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= 8'd0;
                run <= 1'b0;
            end else if (bus.tmr_load) begin
                cnt <= bus.tmr_value;
                run <= 1'b1;
            end else if (run) begin
                if (cnt == 8'd0) run <= 1'b0;
                else             cnt <= cnt - 8'd1;
            end
        end

        assign bus.tmr_co   = (run && cnt == 8'd0) || spur_v[g];
        assign bus.tx_data  = data_v[g];
        assign bus.tx_valid = valid_v[g];
        assign txd_v[g]     = bus.txd;
        assign busy_v[g]    = bus.tx_busy;
        assign done_v[g]    = bus.tx_done;
        assign ready_v[g]   = bus.tx_ready;
        assign load_v[g]    = bus.tmr_load;
        assign value_v[g]   = bus.tmr_value;

        uart_tx_seq #(
            .BAUD_DIV  (baud_of(g)),
            .PARITY    (par_of(g)),
            .STOP_BITS (stop_of(g))
        ) dut (
            .CLOCK (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    // Sends n (1 or 2) bytes on instance g, back to back, checking every cycle against the model.
    task automatic send_frames(input int g, input int n, input logic [7:0] b0, input logic [7:0] b1);
        int bd, f, k, pos;
        logic [7:0] cur;
        logic e_txd, e_busy, e_done, e_ready, e_load;
        bd = baud_of(g);
        f  = frame_len(g);
        obs_bits.delete();
        busy_cnt = 0;
        load_cnt = 0;
        done_at  = -1;

        @(negedge clk);
        data_v[g]  = b0;
        valid_v[g] = 1'b1;
        #1;
        if (ready_v[g] !== 1'b1) begin
            n_fail++; $display("FAIL accept_ready g%0d: got %b want 1", g, ready_v[g]);
        end
        n_checks++;
        if (load_v[g] !== 1'b1) begin
            n_fail++; $display("FAIL accept_load g%0d: got %b want 1", g, load_v[g]);
        end
        n_checks++;
        load_cnt += int'(load_v[g]);

        for (int j = 1; j <= n * f + 1; j++) begin
            @(negedge clk);
            if (j < n * f && j % f == 0) begin
                valid_v[g] = 1'b1;
                data_v[g]  = b1;
            end else if (j >= n * f) begin
                valid_v[g] = 1'b0;
            end else begin
                valid_v[g] = 1'($urandom);
                data_v[g]  = 8'($urandom);
            end
            #1;
            k   = (j - 1) / f;
            pos = (j - 1) % f;
            cur = (k == 0) ? b0 : b1;
            e_txd   = (j <= n * f) ? exp_bit(g, cur, pos / bd) : 1'b1;
            e_busy  = (j <= n * f);
            e_done  = (j > 1) && ((j - 1) % f == 0);
            e_ready = (j % f == 0) || (j > n * f);
            e_load  = (j < n * f) && (j % bd == 0);

            if (txd_v[g] !== e_txd) begin
                n_fail++; $display("FAIL txd g%0d cyc%0d: got %b want %b", g, j, txd_v[g], e_txd);
            end
            n_checks++;
            if (busy_v[g] !== e_busy) begin
                n_fail++; $display("FAIL busy g%0d cyc%0d: got %b want %b", g, j, busy_v[g], e_busy);
            end
            n_checks++;
            if (done_v[g] !== e_done) begin
                n_fail++; $display("FAIL done g%0d cyc%0d: got %b want %b", g, j, done_v[g], e_done);
            end
            n_checks++;
            if (ready_v[g] !== e_ready) begin
                n_fail++; $display("FAIL ready g%0d cyc%0d: got %b want %b", g, j, ready_v[g], e_ready);
            end
            n_checks++;
            if (load_v[g] !== e_load) begin
                n_fail++; $display("FAIL load g%0d cyc%0d: got %b want %b", g, j, load_v[g], e_load);
            end
            n_checks++;

            if (busy_v[g] === 1'b1) busy_cnt++;
            if (done_v[g] === 1'b1) done_at = j;
            if (j <= n * f) begin
                load_cnt += int'(load_v[g]);
                if (pos % bd == bd / 2) obs_bits.push_back(txd_v[g]);
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        valid_v = '1;
        spur_v  = '0;
        data_v  = '0;
        @(negedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            if (load_v[g] !== 1'b0) begin
                n_fail++; $display("FAIL rst_load g%0d: got %b want 0", g, load_v[g]);
            end
            n_checks++;
            if (txd_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0) begin
                n_fail++; $display("FAIL rst_outs g%0d: got txd%b busy%b done%b want 1 0 0",
                                   g, txd_v[g], busy_v[g], done_v[g]);
            end
            n_checks++;
            if (value_v[g] !== 8'(baud_of(g) - 1)) begin
                n_fail++; $display("FAIL tmr_value g%0d: got %0d want %0d", g, value_v[g], baud_of(g) - 1);
            end
            n_checks++;
        end
        @(negedge clk);
        reset   = 1'b0;
        valid_v = '0;
        #1;
        for (int g = 0; g < NI; g++) begin
            if (ready_v[g] !== 1'b1 || load_v[g] !== 1'b0) begin
                n_fail++; $display("FAIL rel_ready g%0d: got ready%b load%b want 1 0", g, ready_v[g], load_v[g]);
            end
            n_checks++;
        end
    endtask

    task automatic test_basic_frame();
        logic [9:0] got;
        send_frames(0, 1, 8'hA5, 8'h00);
        got = '0;
        for (int i = 0; i < 10 && i < obs_bits.size(); i++) got[9-i] = obs_bits[i];
        if (obs_bits.size() != 10 || got !== 10'b0101001011) begin
            n_fail++; $display("FAIL a5_bits: got %b (%0d) want 0101001011 (10)", got, obs_bits.size());
        end
        n_checks++;
        if (busy_cnt != 40 || done_at != 41) begin
            n_fail++; $display("FAIL a5_len: got busy%0d done@%0d want 40 41", busy_cnt, done_at);
        end
        n_checks++;
    endtask

    task automatic test_parity();
        for (int g = 1; g <= 2; g++) begin
            send_frames(g, 1, 8'hA5, 8'h00);
            if (obs_bits.size() != 11 || obs_bits[9] !== ((g == 1) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL parity_bit g%0d: got %b want %b", g,
                                   (obs_bits.size() > 9) ? obs_bits[9] : 1'bx, (g == 2));
            end
            n_checks++;
            if (busy_cnt != 44) begin
                n_fail++; $display("FAIL parity_len g%0d: got %0d want 44", g, busy_cnt);
            end
            n_checks++;
        end
    endtask

    task automatic test_back_to_back();
        send_frames(3, 2, 8'hFF, 8'h00);
        if (obs_bits.size() != 22 || obs_bits[9] !== 1'b1 || obs_bits[10] !== 1'b1 || obs_bits[11] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_edge: got size%0d stop/start wrong want 22 1 1 0", obs_bits.size());
        end
        n_checks++;
        if (busy_cnt != 88 || done_at != 89) begin
            n_fail++; $display("FAIL b2b_len: got busy%0d done@%0d want 88 89", busy_cnt, done_at);
        end
        n_checks++;
    endtask

    task automatic test_min_baud();
        send_frames(4, 1, 8'h01, 8'h00);
        if (load_cnt != 10) begin
            n_fail++; $display("FAIL min_baud_loads: got %0d want 10", load_cnt);
        end
        n_checks++;
        if (busy_cnt != 20) begin
            n_fail++; $display("FAIL min_baud_len: got %0d want 20", busy_cnt);
        end
        n_checks++;
    endtask

    task automatic test_reset_abort(input int g, input logic [7:0] b, input int abort_j);
        @(negedge clk);
        data_v[g]  = b;
        valid_v[g] = 1'b1;
        for (int j = 1; j <= abort_j; j++) begin
            @(negedge clk);
            valid_v[g] = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        if (txd_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || load_v[g] !== 1'b0) begin
            n_fail++; $display("FAIL abort_async g%0d: got txd%b busy%b load%b want 1 0 0",
                               g, txd_v[g], busy_v[g], load_v[g]);
        end
        n_checks++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        if (ready_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || txd_v[g] !== 1'b1) begin
            n_fail++; $display("FAIL abort_release g%0d: got ready%b busy%b txd%b want 1 0 1",
                               g, ready_v[g], busy_v[g], txd_v[g]);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_frame();
        test_reset_abort(0, 8'h3C, 18);
        send_frames(0, 1, 8'h55, 8'h00);
        if (done_at != 41) begin
            n_fail++; $display("FAIL after_abort_done: got %0d want 41", done_at);
        end
        n_checks++;
        for (int r = 0; r < 3; r++) begin
            int g;
            g = $urandom_range(0, NI - 1);
            test_reset_abort(g, 8'($urandom), $urandom_range(1, frame_len(g) - 1));
        end
    endtask

    task automatic test_idle_tmr_co();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            valid_v = '0;
            for (int g = 0; g < NI; g++) begin
                spur_v[g] = 1'($urandom);
                data_v[g] = 8'($urandom);
            end
            #1;
            for (int g = 0; g < NI; g++) begin
                if (txd_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0 ||
                    ready_v[g] !== 1'b1 || load_v[g] !== 1'b0) begin
                    n_fail++; $display("FAIL idle_co g%0d cyc%0d: got txd%b busy%b done%b ready%b load%b want 1 0 0 1 0",
                                       g, c, txd_v[g], busy_v[g], done_v[g], ready_v[g], load_v[g]);
                end
                n_checks++;
            end
        end
        @(negedge clk);
        spur_v = '0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 14; r++) begin
            int g, n;
            g = $urandom_range(0, NI - 1);
            n = $urandom_range(1, 2);
            send_frames(g, n, 8'($urandom), 8'($urandom));
            if (busy_cnt != n * frame_len(g) || done_at != n * frame_len(g) + 1) begin
                n_fail++; $display("FAIL rand_len g%0d n%0d: got busy%0d done@%0d want %0d %0d",
                                   g, n, busy_cnt, done_at, n * frame_len(g), n * frame_len(g) + 1);
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_min_baud();
        test_reset_mid_frame();
        test_idle_tmr_co();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
